// File: rtl/clk_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clk_step_ctrl                                          |
// | Description : Free-run / single-step clock-enable controller with    |
// |               ClkDiv tick detection and a debounced step button.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module clk_step_ctrl #(
  parameter logic [15:0] DebounceCycles = 16'd1000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ClkDiv,
  input  logic        RunReq,
  input  logic        StepBtn,
  input  logic        HaltReq,
  input  logic        CountClr,
  output logic        ClkEn,
  output logic [1:0]  State,
  output logic [15:0] StepCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [15:0] c_db_last = DebounceCycles - 16'd1;

  state_t      r_state;
  logic        r_clk_en;
  logic [15:0] r_step_count;

  logic        r_div_s1;
  logic        r_div_s2;
  logic        r_div_d;
  logic        r_div_s1_vld;
  logic        r_div_armed;

  logic        r_btn_s1;
  logic        r_btn_s2;
  logic        r_btn_lvl;
  logic        r_btn_lvl_d;
  logic [15:0] r_db_cnt;

  logic        w_tick;
  logic        w_press;
  logic        w_issue;

  // Tick only once ClkDiv has really been seen low since reset.
  assign w_tick  = r_div_s2 & ~r_div_d & r_div_armed;
  assign w_press = r_btn_lvl & ~r_btn_lvl_d;
  assign w_issue = w_tick & ~r_clk_en & ~HaltReq &
                   ((r_state == RUN) || (r_state == STEP));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_div_s1     <= 1'b0;
      r_div_s2     <= 1'b0;
      r_div_d      <= 1'b0;
      r_div_s1_vld <= 1'b0;
      r_div_armed  <= 1'b0;
      r_btn_s1     <= 1'b0;
      r_btn_s2     <= 1'b0;
    end else begin
      r_div_s1     <= ClkDiv;
      r_div_s2     <= r_div_s1;
      r_div_d      <= r_div_s2;
      r_div_s1_vld <= 1'b1;
      r_div_armed  <= r_div_armed | (r_div_s1_vld & ~r_div_s1);
      r_btn_s1     <= StepBtn;
      r_btn_s2     <= r_btn_s1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_btn_lvl   <= 1'b0;
      r_btn_lvl_d <= 1'b0;
      r_db_cnt    <= 16'd0;
    end else begin
      r_btn_lvl_d <= r_btn_lvl;
      if (r_btn_s2 != r_btn_lvl) begin
        if (r_db_cnt == c_db_last) begin
          r_btn_lvl <= r_btn_s2;
          r_db_cnt  <= 16'd0;
        end else begin
          r_db_cnt  <= r_db_cnt + 16'd1;
        end
      end else begin
        r_db_cnt <= 16'd0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_clk_en     <= 1'b0;
      r_step_count <= 16'd0;
    end else begin
      r_clk_en <= w_issue;

      if (CountClr) begin
        r_step_count <= 16'd0;
      end else if (w_issue) begin
        r_step_count <= r_step_count + 16'd1;
      end

      case (r_state)
        IDLE: begin
          if (RunReq) begin
            r_state <= RUN;
          end else if (w_press) begin
            r_state <= STEP;
          end
        end
        RUN: begin
          if (HaltReq) begin
            r_state <= HALTED;
          end else if (!RunReq) begin
            r_state <= IDLE;
          end
        end
        STEP: begin
          if (HaltReq) begin
            r_state <= HALTED;
          end else if (w_issue) begin
            r_state <= IDLE;
          end
        end
        HALTED: begin
          if (!RunReq) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ClkEn     = r_clk_en;
  assign State     = r_state;
  assign StepCount = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_clk_step_ctrl.sv
`default_nettype none
// Directed bench for clk_step_ctrl with DebounceCycles=4; inputs change and
// outputs are sampled on the falling clock edge.
module tb_clk_step_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ClkDiv = 1'b0;
  logic        RunReq = 1'b0;
  logic        StepBtn = 1'b0;
  logic        HaltReq = 1'b0;
  logic        CountClr = 1'b0;
  logic        ClkEn;
  logic [1:0]  State;
  logic [15:0] StepCount;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int dbl = 0;
  int p0 = 0;
  logic prev_en = 1'b0;

  clk_step_ctrl #(.DebounceCycles(16'd4)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .ClkDiv    (ClkDiv),
    .RunReq    (RunReq),
    .StepBtn   (StepBtn),
    .HaltReq   (HaltReq),
    .CountClr  (CountClr),
    .ClkEn     (ClkEn),
    .State     (State),
    .StepCount (StepCount)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (ClkEn) pulses <= pulses + 1;
    if (ClkEn && prev_en) dbl <= dbl + 1;
    prev_en <= ClkEn;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic div_period();
    ClkDiv = 1'b1;
    cyc(5);
    ClkDiv = 1'b0;
    cyc(5);
  endtask

  initial begin
    // reset state
    cyc(3);
    chk("rst_clken", 32'(ClkEn), 32'd0);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_count", 32'(StepCount), 32'd0);
    Rst_n = 1'b1;
    cyc(2);

    // free run: latency and five pulses
    RunReq = 1'b1;
    cyc(1);
    chk("run_state", 32'(State), 32'd1);
    ClkDiv = 1'b1;
    cyc(1);
    chk("lat_e1", 32'(ClkEn), 32'd0);
    cyc(1);
    chk("lat_e2", 32'(ClkEn), 32'd0);
    cyc(1);
    chk("lat_e3", 32'(ClkEn), 32'd1);
    chk("lat_cnt", 32'(StepCount), 32'd1);
    cyc(1);
    chk("lat_e4", 32'(ClkEn), 32'd0);
    cyc(1);
    ClkDiv = 1'b0;
    cyc(5);
    repeat (4) div_period();
    chk("run_pulses", 32'(pulses), 32'd5);
    chk("run_count", 32'(StepCount), 32'd5);

    // halt coinciding with tick
    ClkDiv = 1'b1;
    cyc(2);
    HaltReq = 1'b1;
    cyc(1);
    HaltReq = 1'b0;
    chk("halt_clken", 32'(ClkEn), 32'd0);
    chk("halt_state", 32'(State), 32'd3);
    cyc(3);
    ClkDiv = 1'b0;
    cyc(5);
    div_period();
    chk("halt_hold", 32'(State), 32'd3);
    chk("halt_pulses", 32'(pulses), 32'd5);
    RunReq = 1'b0;
    cyc(1);
    chk("halt_exit", 32'(State), 32'd0);

    // clear, then bouncing button and single step
    CountClr = 1'b1;
    cyc(1);
    CountClr = 1'b0;
    chk("clr_count", 32'(StepCount), 32'd0);
    for (int i = 0; i < 6; i++) begin
      StepBtn = (i % 2 == 0);
      cyc(1);
    end
    chk("bounce_idle", 32'(State), 32'd0);
    StepBtn = 1'b1;
    cyc(10);
    chk("step_state", 32'(State), 32'd2);
    StepBtn = 1'b0;
    cyc(8);
    StepBtn = 1'b1;
    cyc(8);
    StepBtn = 1'b0;
    cyc(8);
    p0 = pulses;
    div_period();
    div_period();
    chk("step_pulses", 32'(pulses - p0), 32'd1);
    chk("step_done", 32'(State), 32'd0);
    chk("step_count", 32'(StepCount), 32'd1);

    // counter wrap and clear-over-increment
    RunReq = 1'b1;
    cyc(1);
    force dut.r_step_count = 16'hFFFF;
    #1;
    release dut.r_step_count;
    chk("wrap_pre", 32'(StepCount), 32'hFFFF);
    p0 = pulses;
    div_period();
    chk("wrap_count", 32'(StepCount), 32'd0);
    chk("wrap_pulse", 32'(pulses - p0), 32'd1);
    ClkDiv = 1'b1;
    cyc(2);
    CountClr = 1'b1;
    cyc(1);
    CountClr = 1'b0;
    chk("clr_en", 32'(ClkEn), 32'd1);
    chk("clr_prio", 32'(StepCount), 32'd0);
    cyc(2);
    ClkDiv = 1'b0;
    cyc(5);
    div_period();
    chk("pre_rst_cnt", 32'(StepCount), 32'd1);

    // reset mid-STEP with ClkDiv high
    RunReq = 1'b0;
    cyc(1);
    StepBtn = 1'b1;
    cyc(10);
    StepBtn = 1'b0;
    chk("rst_step", 32'(State), 32'd2);
    cyc(8);
    ClkDiv = 1'b1;
    cyc(1);
    Rst_n = 1'b0;
    #1;
    chk("arst_clken", 32'(ClkEn), 32'd0);
    chk("arst_state", 32'(State), 32'd0);
    chk("arst_count", 32'(StepCount), 32'd0);
    cyc(3);
    Rst_n = 1'b1;
    RunReq = 1'b1;
    p0 = pulses;
    cyc(10);
    chk("post_rst_none", 32'(pulses - p0), 32'd0);
    chk("post_rst_run", 32'(State), 32'd1);
    ClkDiv = 1'b0;
    cyc(5);
    ClkDiv = 1'b1;
    cyc(5);
    chk("post_rst_tick", 32'(pulses - p0), 32'd1);

    // RunReq and press in the same cycle
    ClkDiv = 1'b0;
    RunReq = 1'b0;
    cyc(5);
    chk("prio_idle", 32'(State), 32'd0);
    StepBtn = 1'b1;
    cyc(6);
    RunReq = 1'b1;
    cyc(1);
    chk("prio_run", 32'(State), 32'd1);
    p0 = pulses;
    StepBtn = 1'b0;
    div_period();
    StepBtn = 1'b1;
    div_period();
    StepBtn = 1'b0;
    div_period();
    chk("prio_pulses", 32'(pulses - p0), 32'd3);
    chk("prio_state", 32'(State), 32'd1);
    RunReq = 1'b0;
    cyc(1);
    chk("final_idle", 32'(State), 32'd0);
    chk("no_double", 32'(dbl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter DebounceCycles, default 16'd1000, is the number of consecutive stable Clk cycles needed to accept a StepBtn level change; legal range 1..65535.
REQ-002 Clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ClkDiv  input  1  slow tick produced by the clock divider stage.
REQ-005 RunReq  input  1  level request for free-run mode.
REQ-006 StepBtn  input  1  raw, bouncing single-step push button, active-high.
REQ-007 HaltReq  input  1  one-cycle halt pulse from the core.
REQ-008 CountClr  input  1  synchronous clear of StepCount.
REQ-009 ClkEn  output  1  registered one-Clk-cycle enable pulse to the core.
REQ-010 State  output  2  current FSM state: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-011 StepCount  output  16  number of ClkEn pulses issued.

Function
REQ-012 ClkDiv and StepBtn SHALL each pass through a two-flop synchronizer before any use.
REQ-013 Tick: a rising edge of synchronized ClkDiv, detected as sync=1 while its one-cycle-delayed copy is 0.
REQ-014 ClkEn latency: ClkEn SHALL be high for exactly the cycle starting at the second Clk edge after the edge that first samples ClkDiv=1.
REQ-015 Debounce: the debounced level SHALL take the synchronized StepBtn value only after that value differs from it for DebounceCycles consecutive cycles; any cycle of agreement SHALL reset the debounce counter to 0.
REQ-016 Press: a 0->1 transition of the debounced level, one cycle wide.
REQ-017 IDLE: RunReq=1 -> RUN; else a Press -> STEP; no ClkEn.
REQ-018 RUN: each Tick SHALL produce one ClkEn; RunReq=0 -> IDLE; Presses ignored.
REQ-019 STEP: the first Tick SHALL produce exactly one ClkEn and go to IDLE in the same transition; further Presses while in STEP are dropped (no queuing).
REQ-020 HALTED: no ClkEn; leave to IDLE only when RunReq=0; Presses ignored.
REQ-021 HaltReq=1 in RUN or STEP -> HALTED; HaltReq in IDLE or HALTED has no effect.
REQ-022 Priority, same cycle: HaltReq over Tick (no ClkEn issued); RunReq over Press in IDLE.
REQ-023 StepCount SHALL increment by 1 in the cycle ClkEn is registered high; wrap 16'hFFFF -> 16'h0000.
REQ-024 CountClr SHALL load StepCount with 0 and take priority over a simultaneous increment.
REQ-025 ClkEn SHALL never be high on two consecutive cycles.

Reset
REQ-026 Rst_n=0 SHALL immediately force State=IDLE, ClkEn=0, StepCount=0, all synchronizer and edge-detect flops to 0, debounced level to 0, and the debounce counter to 0.
REQ-027 Reset asserted mid-STEP or mid-debounce SHALL discard the pending step or press; after release the FSM SHALL act only on new Ticks and Presses.
REQ-028 After Rst_n deasserts, a ClkDiv already high SHALL NOT produce a Tick until ClkDiv has been sampled low and then high.

Verification (DebounceCycles=4)
REQ-029 RunReq=1, ClkDiv toggling with period 10 Clk, 5 periods -> 5 ClkEn pulses, each one cycle wide at REQ-014 latency, StepCount=5.
REQ-030 IDLE, StepBtn bounces 1/0/1 on alternate cycles then holds 1 for 10 cycles, ClkDiv ticking -> exactly one Press, State goes 00->10->00, one ClkEn, StepCount=1.
REQ-031 RUN, HaltReq pulsed in the same cycle as a Tick -> no ClkEn, State=11; with RunReq still 1 State stays 11; RunReq=0 -> State=00.
REQ-032 StepCount preset by 65535 pulses in RUN, one more Tick -> StepCount=0; CountClr asserted in the same cycle as a ClkEn -> StepCount=0.
REQ-033 Rst_n pulsed low while State=10 with ClkDiv held high -> outputs 0/00/0 immediately; after release, no ClkEn until ClkDiv goes low and then high again.
REQ-034 IDLE, RunReq=1 and a Press in the same cycle -> State=01; a later release and re-press of StepBtn -> no extra ClkEn beyond Ticks.
